// File: rtl/ilv_pkg.sv
// Shared interleaver definitions: default block geometry, widths and the
// word record that travels through the output pipeline.
package ilv_pkg;

    localparam int ILV_C          = 65;
    localparam int ILV_N          = 4;
    localparam int ILV_BLOCK_SIZE = ILV_C * ILV_N;
    localparam int ILV_DW         = 32;

    // Counter width that never collapses to zero for tiny geometries.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int ILV_IDX_W = clog2_min1(ILV_BLOCK_SIZE);

    typedef struct packed {
        logic              last;
        logic [ILV_DW-1:0] data;
    } ilv_word_t;

endpackage

// File: rtl/deint_bank_ram.sv
// Simple dual-port RAM holding both ping-pong banks. Address is {bank, flat_idx},
// so each bank occupies a power-of-2 aligned half; registered read port.
module deint_bank_ram #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // synchronous read port
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/post_deinterleaver.sv
// RX de-interleaver: writes a block in row order into one bank while the other
// bank drains in codeword order through a sync RAM read and a 2-entry skid.
module post_deinterleaver
    import ilv_pkg::*;
#(
    parameter int CODEWORD_SIZE_IN_32 = ILV_C,
    parameter int NUM_CODEWORDS       = ILV_N
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        align_err
);

    localparam int C      = CODEWORD_SIZE_IN_32;
    localparam int N      = NUM_CODEWORDS;
    localparam int BS     = C * N;
    localparam int IDX_W  = clog2_min1(BS);
    localparam int CW_W   = clog2_min1(N);
    localparam int ADDR_W = clog2_min1(C);
    localparam int RD_STAGES = 1;

    // control state
    logic              rdy_en;
    logic [1:0]        full;
    logic              wr_bank, rd_bank;
    logic [CW_W-1:0]   wr_cw;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [IDX_W-1:0]  wr_flat, rd_j;

    // read pipeline and skid
    logic [RD_STAGES:1] vld_pipe;
    logic               last_p1;
    logic [31:0]        ram_q;
    ilv_word_t          e0, e1, push_w;
    logic [1:0]         cnt, occ;

    logic s_accept, wr_end, rd_issue, rd_end, pop, push;

    assign s_axis_tready = rdy_en && !full[wr_bank];
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign wr_end        = (wr_cw == CW_W'(N - 1)) && (wr_addr == ADDR_W'(C - 1));

    assign m_axis_tvalid = (cnt != 2'd0);
    assign m_axis_tdata  = e0.data;
    assign m_axis_tlast  = e0.last;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign push          = vld_pipe[1];
    assign push_w        = '{last: last_p1, data: ram_q};

    // words in flight (RAM stage) plus words held must stay within the skid depth
    assign occ      = cnt + {1'b0, vld_pipe[1]};
    assign rd_issue = full[rd_bank] && ((occ != 2'd2) || pop);
    assign rd_end   = (rd_j == IDX_W'(BS - 1));

    deint_bank_ram #(.AW(IDX_W + 1), .DW(32)) u_ram (
        .clk   (clk),
        .we    (s_accept),
        .waddr ({wr_bank, wr_flat}),
        .wdata (s_axis_tdata),
        .re    (rd_issue),
        .raddr ({rd_bank, rd_j}),
        .rdata (ram_q)
    );

    // input ready held low through reset, enabled from the first cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // write sub-counters: flat index advances by C per codeword, restarts at addr+1 per row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            wr_cw   <= '0;
            wr_addr <= '0;
            wr_flat <= '0;
        end else if (s_accept) begin
            if (wr_end) begin
                wr_bank <= ~wr_bank;
                wr_cw   <= '0;
                wr_addr <= '0;
                wr_flat <= '0;
            end else if (wr_cw == CW_W'(N - 1)) begin
                wr_cw   <= '0;
                wr_addr <= wr_addr + ADDR_W'(1);
                wr_flat <= IDX_W'(wr_addr) + IDX_W'(1);
            end else begin
                wr_cw   <= wr_cw + CW_W'(1);
                wr_flat <= wr_flat + IDX_W'(C);
            end
        end
    end

    // bank full flags: set by last write, cleared by last read issue (never the same bank)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            if (s_accept && wr_end) full[wr_bank] <= 1'b1;
            if (rd_issue && rd_end) full[rd_bank] <= 1'b0;
        end
    end

    // sticky tlast misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                align_err <= 1'b0;
        else if (s_accept && (s_axis_tlast != wr_end)) align_err <= 1'b1;
    end

    // read issue counters and RAM-stage valid/tlast
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank  <= 1'b0;
            rd_j     <= '0;
            rd_addr  <= '0;
            vld_pipe <= '0;
            last_p1  <= 1'b0;
        end else begin
            vld_pipe[1] <= rd_issue;
            if (rd_issue) begin
                last_p1 <= (rd_addr == ADDR_W'(C - 1));
                if (rd_end) begin
                    rd_bank <= ~rd_bank;
                    rd_j    <= '0;
                    rd_addr <= '0;
                end else begin
                    rd_j    <= rd_j + IDX_W'(1);
                    rd_addr <= (rd_addr == ADDR_W'(C - 1)) ? '0 : rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    // 2-entry output skid; e0 is the presented word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= push_w;
                    else             e1 <= push_w;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= push_w;
                    end else begin
                        e0 <= e1;
                        e1 <= push_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
